rv32_decode_stage: RTL
======================

// Module: rv32_decode_stage
// PURPOSE
//  Registered, flow-controlled RV32I(+M) decode stage between fetch and execute.
//  Cracks each instruction into register addresses, immediate, opcode and mnemonic.
//  Adds a 2-entry skid buffer, a flush, an illegal-instruction flag and a decoded-instruction counter.
//  Successor to the single-cycle combinational decoder.
// PARAMETERS
//  XLEN     32  immediate / datapath width (32 or 64); immediates sign-extend to XLEN
//  PC_W     32  width of the PC carried alongside each instruction
//  CNT_W    32  width of the decoded-instruction counter
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      asynchronous active-low reset
//  flush_i       in   1      discard all buffered instructions
//  in_valid_i    in   1      fetch offers in_instr_i / in_pc_i
//  in_ready_o    out  1      stage accepts an instruction this cycle
//  in_instr_i    in   32     raw instruction bits
//  in_pc_i       in   PC_W   PC of in_instr_i
//  out_valid_o   out  1      decoded bundle valid
//  out_ready_i   in   1      execute accepts the bundle
//  out_pc_o      out  PC_W   PC of the decoded instruction
//  out_rs1_o     out  5      rs1 address (0 if unused)
//  out_rs2_o     out  5      rs2 address (0 if unused)
//  out_rd_o      out  5      rd address (0 if unused)
//  out_imm_o     out  XLEN   sign-extended immediate (0 for R-type)
//  out_opcode_o  out  7      RV32I_OPCODE_t
//  out_mnem_o    out  enum   RV32I_INSTRUCTION_MNEMONIC_t, NULL when illegal
//  out_illegal_o out  1      unknown opcode / funct3 / funct7 combination
//  dec_count_o   out  CNT_W  instructions handed to execute since reset/clear
// BEHAVIOUR
//  - Reset: all entries empty, out_valid_o=0, in_ready_o=1, all out_* data=0, dec_count_o=0.
//  - Decode is combinational on in_instr_i; the result is captured on an input handshake (in_valid_i & in_ready_o).
//  - Latency: 1 cycle from input handshake to out_valid_o. Throughput: 1/cycle while out_ready_i=1.
//  - Buffer FSM with states EMPTY, ONE, TWO (main entry drives out_*, skid entry behind it):
//    EMPTY -in hs-> ONE; ONE -in hs & !out hs-> TWO; ONE -out hs & !in hs-> EMPTY;
//    ONE -both-> ONE (main reloaded); TWO -out hs-> ONE (skid moves to main).
//  - in_ready_o = (state != TWO), driven from a flop (no combinational path from out_ready_i).
//  - out_* data are stable while out_valid_o=1 & out_ready_i=0.
//  - flush_i: next state EMPTY, and any input handshake in the same cycle is dropped.
//    dec_count_o still counts an output handshake occurring in that cycle.
//  - Illegal: out_illegal_o=1, mnem=NULL, rs1/rs2/rd/imm=0. The instruction still flows and is counted.
//  - SRLI/SRAI and SRL/SRA are selected by instr[30]; any other nonzero funct7 bit is illegal.
//  - ECALL/EBREAK: imm==0 / imm==1; any other value is illegal.
//  - dec_count_o increments on each output handshake and wraps modulo 2^CNT_W.
//  - Reset asserted mid-transfer: the buffered entries are lost, with no partial output.
// CONFIGURATION
//  RV32M_EN defined:
//    opcode R_TYPE with funct7=0000001 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (by funct3).
//  RV32M_EN undefined: funct7=0000001 is illegal (out_illegal_o=1, mnem=NULL).
// STRUCTURE
//  - fe_pkg gains: the M-extension mnemonics; typedef dec_bundle_t {pc, rs1, rs2, rd, imm, opcode, mnem, illegal};
//    typedef dec_state_e {EMPTY, ONE, TWO}.
//  - Sub-module rv32_decode_comb: purely combinational instr -> dec_bundle_t, instantiated once at the input.
//  - This block holds the FSM, the two dec_bundle_t registers and the counter.
// TESTING
//  1. Reset, then in 0x00500093 (addi x1,x0,5), out_ready=1
//     -> next cycle out_valid=1, mnem=ADDI, rd=1, rs1=0, imm=5, dec_count=1.
//  2. Stream 4 instrs with out_ready=0 -> 2 accepted, then in_ready=0;
//     raise out_ready -> all 4 emerge in order with no loss or duplicates, 1 per cycle.
//  3. 0xFE000EE3 (beq x0,x0,-4) -> mnem=BEQ, imm=0xFFFFFFFC; 0x800000EF (jal) -> imm=0xFFF00000.
//  4. 0x02208033 (mul x0,x1,x2) -> MUL, illegal=0 with RV32M_EN; without it, illegal=1, mnem=NULL.
//  5. State TWO, assert flush_i with in_valid_i=1 -> next cycle out_valid=0, in_ready=1, input dropped.
//  6. Opcode 0x7F -> illegal=1, fields 0, still counted; preload counter at 2^CNT_W-1, one handshake -> 0.

Source files
------------

// File: rtl/fe_pkg.sv
// Front-end shared types for the RV32I(+M) decode stage.
// Optional M extension decode is enabled by defining RV32M_EN.
package fe_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned OPC_W    = 7;
    localparam int unsigned IMM_W    = 32;  // RV32 immediates fit in 32 bits; widened to XLEN at the output
    localparam int unsigned DEC_PC_W = 32;  // PC width held in the decode bundle

    typedef enum logic [OPC_W-1:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_FENCE  = 7'b0001111,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } RV32I_OPCODE_t;

    typedef enum logic [5:0] {
        NULL,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } RV32I_INSTRUCTION_MNEMONIC_t;

    typedef struct packed {
        logic [DEC_PC_W-1:0]         pc;
        logic [REG_W-1:0]            rs1;
        logic [REG_W-1:0]            rs2;
        logic [REG_W-1:0]            rd;
        logic [IMM_W-1:0]            imm;
        logic [OPC_W-1:0]            opcode;
        RV32I_INSTRUCTION_MNEMONIC_t mnem;
        logic                        illegal;
    } dec_bundle_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } dec_state_e;

endpackage

// File: rtl/rv32_decode_comb.sv
// Combinational RV32I(+M) instruction cracker: raw bits -> dec_bundle_t.
// Defining RV32M_EN adds the M-extension mnemonics; otherwise funct7=0000001 is illegal.
module rv32_decode_comb
    import fe_pkg::*;
(
    input  logic [INSTR_W-1:0]  instr,
    input  logic [DEC_PC_W-1:0] pc,
    output dec_bundle_t         dec
);

    logic [OPC_W-1:0] opc;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [IMM_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    RV32I_INSTRUCTION_MNEMONIC_t mnem;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{(IMM_W-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(IMM_W-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(IMM_W-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{(IMM_W-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // Pick mnemonic and format fields; anything unrecognised is squashed to an illegal bundle.
    always_comb begin
        dec        = '0;
        dec.pc     = pc;
        dec.opcode = opc;
        mnem       = NULL;
        case (opc)
            OPC_LUI:   begin mnem = LUI;   dec.rd = instr[11:7]; dec.imm = imm_u; end
            OPC_AUIPC: begin mnem = AUIPC; dec.rd = instr[11:7]; dec.imm = imm_u; end
            OPC_JAL:   begin mnem = JAL;   dec.rd = instr[11:7]; dec.imm = imm_j; end
            OPC_JALR: begin
                mnem    = (f3 == 3'b000) ? JALR : NULL;
                dec.rd  = instr[11:7];
                dec.rs1 = instr[19:15];
                dec.imm = imm_i;
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  mnem = BEQ;
                    3'b001:  mnem = BNE;
                    3'b100:  mnem = BLT;
                    3'b101:  mnem = BGE;
                    3'b110:  mnem = BLTU;
                    3'b111:  mnem = BGEU;
                    default: mnem = NULL;
                endcase
                dec.rs1 = instr[19:15];
                dec.rs2 = instr[24:20];
                dec.imm = imm_b;
            end
            OPC_LOAD: begin
                case (f3)
                    3'b000:  mnem = LB;
                    3'b001:  mnem = LH;
                    3'b010:  mnem = LW;
                    3'b100:  mnem = LBU;
                    3'b101:  mnem = LHU;
                    default: mnem = NULL;
                endcase
                dec.rd  = instr[11:7];
                dec.rs1 = instr[19:15];
                dec.imm = imm_i;
            end
            OPC_STORE: begin
                case (f3)
                    3'b000:  mnem = SB;
                    3'b001:  mnem = SH;
                    3'b010:  mnem = SW;
                    default: mnem = NULL;
                endcase
                dec.rs1 = instr[19:15];
                dec.rs2 = instr[24:20];
                dec.imm = imm_s;
            end
            OPC_OP_IMM: begin
                case (f3)
                    3'b000:  mnem = ADDI;
                    3'b010:  mnem = SLTI;
                    3'b011:  mnem = SLTIU;
                    3'b100:  mnem = XORI;
                    3'b110:  mnem = ORI;
                    3'b111:  mnem = ANDI;
                    3'b001:  mnem = (f7 == 7'b0000000) ? SLLI : NULL;
                    3'b101:  mnem = (f7 == 7'b0000000) ? SRLI :
                                    (f7 == 7'b0100000) ? SRAI : NULL;
                    default: mnem = NULL;
                endcase
                dec.rd  = instr[11:7];
                dec.rs1 = instr[19:15];
                dec.imm = imm_i;  // shifts keep the raw I-immediate, funct7 bits included
            end
            OPC_OP: begin
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:  mnem = ADD;
                            3'b001:  mnem = SLL;
                            3'b010:  mnem = SLT;
                            3'b011:  mnem = SLTU;
                            3'b100:  mnem = XOR;
                            3'b101:  mnem = SRL;
                            3'b110:  mnem = OR;
                            default: mnem = AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (f3)
                            3'b000:  mnem = SUB;
                            3'b101:  mnem = SRA;
                            default: mnem = NULL;
                        endcase
                    end
`ifdef RV32M_EN
                    7'b0000001: begin
                        case (f3)
                            3'b000:  mnem = MUL;
                            3'b001:  mnem = MULH;
                            3'b010:  mnem = MULHSU;
                            3'b011:  mnem = MULHU;
                            3'b100:  mnem = DIV;
                            3'b101:  mnem = DIVU;
                            3'b110:  mnem = REM;
                            default: mnem = REMU;
                        endcase
                    end
`endif
                    default: mnem = NULL;
                endcase
                dec.rd  = instr[11:7];
                dec.rs1 = instr[19:15];
                dec.rs2 = instr[24:20];
            end
            OPC_FENCE: begin
                mnem    = (f3 == 3'b000) ? FENCE : NULL;
                dec.rd  = instr[11:7];
                dec.rs1 = instr[19:15];
                dec.imm = imm_i;
            end
            OPC_SYSTEM: begin
                if (f3 == 3'b000 && instr[31:20] == 12'd0) begin
                    mnem = ECALL;
                end else if (f3 == 3'b000 && instr[31:20] == 12'd1) begin
                    mnem = EBREAK;
                end else begin
                    mnem = NULL;
                end
                dec.imm = imm_i;
            end
            default: mnem = NULL;
        endcase
        if (mnem == NULL) begin
            dec.rs1     = '0;
            dec.rs2     = '0;
            dec.rd      = '0;
            dec.imm     = '0;
            dec.illegal = 1'b1;
        end
        dec.mnem = mnem;
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// Registered RV32I(+M) decode stage with 2-entry skid buffer, flush and handoff counter.
// Define RV32M_EN to decode the M extension.
module rv32_decode_stage
    import fe_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [INSTR_W-1:0]          in_instr_i,
    input  logic [PC_W-1:0]             in_pc_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [PC_W-1:0]             out_pc_o,
    output logic [REG_W-1:0]            out_rs1_o,
    output logic [REG_W-1:0]            out_rs2_o,
    output logic [REG_W-1:0]            out_rd_o,
    output logic [XLEN-1:0]             out_imm_o,
    output logic [OPC_W-1:0]            out_opcode_o,
    output RV32I_INSTRUCTION_MNEMONIC_t out_mnem_o,
    output logic                        out_illegal_o,
    output logic [CNT_W-1:0]            dec_count_o
);

    dec_state_e       state_q, state_d;
    dec_bundle_t      main_q, main_d, skid_q, skid_d, dec;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_hs, out_hs;

    rv32_decode_comb u_dec (
        .instr (in_instr_i),
        .pc    (DEC_PC_W'(in_pc_i)),
        .dec   (dec)
    );

    // A flush drops any same-cycle input handshake.
    assign in_hs  = in_valid_i & in_ready_q & ~flush_i;
    assign out_hs = out_valid_q & out_ready_i;

    // Buffer occupancy, entry movement and counter next-state.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_hs) begin
                        main_d  = dec;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_hs && out_hs) begin
                        main_d = dec;
                    end else if (in_hs) begin
                        skid_d  = dec;
                        state_d = TWO;
                    end else if (out_hs) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_hs) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
        count_d     = count_q + CNT_W'(out_hs);
    end

    // State, entries, handshake flags and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
        end
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign out_pc_o      = PC_W'(main_q.pc);
    assign out_rs1_o     = main_q.rs1;
    assign out_rs2_o     = main_q.rs2;
    assign out_rd_o      = main_q.rd;
    assign out_imm_o     = XLEN'($signed(main_q.imm));
    assign out_opcode_o  = main_q.opcode;
    assign out_mnem_o    = main_q.mnem;
    assign out_illegal_o = main_q.illegal;
    assign dec_count_o   = count_q;

endmodule
